pipelined_cla_subtractor: RTL and testbench
===========================================

// Module: pipelined_cla_subtractor
// PURPOSE
//  Unsigned/two's-complement subtractor: diff = in1 - in2 - borrow_in, with borrow_out.
//  Pipelined over STAGES chunks, each chunk a carry-look-ahead slice computing in1 + ~in2 + ~borrow.
//  Sits beside the N-bit CLA adder in the datapath and feeds the compare/decrement paths.
//  Uses a valid/ready handshake on both ends.
// PARAMETERS
//  DATA_WID  32  operand and result width; must be divisible by STAGES
//  STAGES     4  pipeline depth; chunk width CW = DATA_WID/STAGES; legal values 1..DATA_WID
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         operand beat valid
//  in_ready   out  1         unit accepts a beat this cycle
//  in1        in   DATA_WID  minuend
//  in2        in   DATA_WID  subtrahend
//  borrow_in  in   1         borrow into bit 0
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts the result
//  diff       out  DATA_WID  in1 - in2 - borrow_in, modulo 2^DATA_WID
//  borrow_out out  1         1 iff in1 < in2 + borrow_in (unsigned compare)
//  overflow   out  1         present only with SUB_OVERFLOW_FLAG_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all stage valid bits = 0; out_valid = 0; diff = 0; borrow_out = 0; overflow = 0.
//    Reset mid-operation drops every in-flight beat; no partial result is ever emitted.
//  - Accept: a beat is taken on a rising edge with in_valid && in_ready.
//  - Stall: stall = out_valid && !out_ready. in_ready = !stall, combinational.
//    While stalled, every stage register, including the skew registers, holds.
//  - Stage k (0..STAGES-1) computes bits [k*CW +: CW]:
//    - carry into the slice = ~borrow from stage k-1; stage 0 uses ~borrow_in.
//    - borrow into stage k+1 = ~slice carry-out.
//    - Upper operand chunks and lower result chunks travel in skew registers with the beat.
//  - Latency: exactly STAGES cycles from accept to out_valid when not stalled.
//    Throughput: 1 beat per cycle.
//  - A bubble (in_valid=0) propagates as an invalid stage; bubbles never stall.
//  - out_valid && out_ready with in_valid && in_ready in the same cycle: both transfers occur.
//  - Outputs are registered. diff, borrow_out and overflow are stable while out_valid && !out_ready.
//  - Wrap-around: 0 - 1 gives diff = all-ones and borrow_out = 1.
//    in1 == in2 with borrow_in = 0 gives diff = 0 and borrow_out = 0.
//  - STAGES = 1: a single full-width CLA slice followed by one output register.
// CONFIGURATION
//  SUB_OVERFLOW_FLAG_EN defined:
//    - Port `overflow` exists.
//    - overflow = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]), i.e. signed overflow.
//    - The operand MSBs are carried to the last stage alongside the beat.
//  SUB_OVERFLOW_FLAG_EN undefined:
//    - Port `overflow` and its registers are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  Package sub_pkg:
//    - localparam function chunk_wid(DATA_WID, STAGES).
//    - typedef for the stage payload struct {valid, borrow, a_rem, b_rem, diff_lo}.
//  Sub-module cla_sub_slice:
//    - Parameterised CW, purely combinational.
//    - g = a & ~b, p = a | ~b; carry[i+1] = g | p & carry[i]; sum = a ^ ~b ^ carry.
//    - Instantiated STAGES times inside a generate loop.
//  Top level: stage registers, skew shifting and the stall/handshake logic only.
// TESTING
//  1. in1=32'd100, in2=32'd58, borrow_in=0 -> diff=32'd42, borrow_out=0, out_valid exactly 4 cycles later.
//  2. in1=0, in2=1, borrow_in=0 -> diff=32'hFFFF_FFFF, borrow_out=1; in1=5, in2=5, borrow_in=1 -> diff=all-ones, borrow_out=1.
//  3. Back-to-back 16 random beats with out_ready=1 -> 16 results in order, one per cycle; compare against a golden model.
//  4. Hold out_ready=0 for 6 cycles with the pipe full -> in_ready=0, diff stable, no beat lost or duplicated after release.
//  5. Assert rst with 3 beats in flight -> out_valid=0 next edge; after release the first new beat emerges after 4 cycles.
//  6. With SUB_OVERFLOW_FLAG_EN: in1=32'h8000_0000, in2=1 -> diff=32'h7FFF_FFFF, overflow=1; in1=3, in2=5 -> overflow=0, borrow_out=1.

Source files
------------

// File: rtl/pipelined_cla_subtractor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sub_pkg : chunk-width helper and stage payload for pipelined_cla_subtractor
// Revision: 1.0
// ----------------------------------------------------------------------------
package sub_pkg;

    // Payload fields are sized for the widest supported operand; the top level
    // only touches [DATA_WID-1:0] and the remaining bits are tied to zero.
    localparam int unsigned MAX_DATA_WID = 256;

    function automatic int unsigned chunk_wid(input int unsigned data_wid,
                                              input int unsigned stages);
        return data_wid / stages;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    borrow;
        logic [MAX_DATA_WID-1:0] a_rem;
        logic [MAX_DATA_WID-1:0] b_rem;
        logic [MAX_DATA_WID-1:0] diff_lo;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_subtractor_slice.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cla_sub_slice : combinational CW-bit carry-look-ahead slice computing a + ~b + carry_i
// Revision: 1.0
// ----------------------------------------------------------------------------
module cla_sub_slice #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          carry_i,
    output logic [CW-1:0] sum_o,
    output logic          carry_o
);

    logic [CW-1:0] w_nb;
    logic [CW-1:0] w_g;
    logic [CW-1:0] w_p;
    logic [CW:0]   w_c;

    assign w_nb   = ~b_i;
    assign w_g    = a_i & w_nb;
    assign w_p    = a_i | w_nb;
    assign w_c[0] = carry_i;

    for (genvar i = 0; i < CW; i++) begin : g_carry
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign sum_o   = a_i ^ w_nb ^ w_c[CW-1:0];
    assign carry_o = w_c[CW];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_cla_subtractor : diff = in1 - in2 - borrow_in over STAGES CLA chunks, valid/ready
// Revision: 1.0   Optional signed-overflow port: define SUB_OVERFLOW_FLAG_EN
// ----------------------------------------------------------------------------
module pipelined_cla_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned STAGES   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_WID-1:0] in1,
    input  logic [DATA_WID-1:0] in2,
    input  logic                borrow_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_WID-1:0] diff,
    output logic                borrow_out
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic                overflow
`endif
);

    localparam int unsigned CW   = chunk_wid(DATA_WID, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    logic   w_stall;

`ifdef SUB_OVERFLOW_FLAG_EN
    logic   overflow_q;
    logic   w_ovf_d;
`endif

    assign w_stall  = stage_q[LAST].valid && !out_ready;
    assign in_ready = !w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                w_vld;
        logic                w_bin;
        logic [DATA_WID-1:0] w_a;
        logic [DATA_WID-1:0] w_b;
        logic [DATA_WID-1:0] w_dprev;
        logic [CW-1:0]       w_sum;
        logic                w_cout;
        stage_t              w_next;

        if (k == 0) begin : g_head
            assign w_vld   = in_valid;
            assign w_bin   = borrow_in;
            assign w_a     = in1;
            assign w_b     = in2;
            assign w_dprev = '0;
        end else begin : g_body
            assign w_vld   = stage_q[k-1].valid;
            assign w_bin   = stage_q[k-1].borrow;
            assign w_a     = stage_q[k-1].a_rem[DATA_WID-1:0];
            assign w_b     = stage_q[k-1].b_rem[DATA_WID-1:0];
            assign w_dprev = stage_q[k-1].diff_lo[DATA_WID-1:0];
        end

        cla_sub_slice #(
            .CW (CW)
        ) u_slice (
            .a_i     (w_a[CW-1:0]),
            .b_i     (w_b[CW-1:0]),
            .carry_i (!w_bin),
            .sum_o   (w_sum),
            .carry_o (w_cout)
        );

        // Operands shift down one chunk per stage; result chunks enter from the top
        // so the finished word is aligned after the last stage.
        always_comb begin
            w_next                       = '0;
            w_next.valid                 = w_vld;
            w_next.borrow                = !w_cout;
            w_next.a_rem[DATA_WID-1:0]   = w_a >> CW;
            w_next.b_rem[DATA_WID-1:0]   = w_b >> CW;
            w_next.diff_lo[DATA_WID-1:0] = (w_dprev >> CW)
                                         | (DATA_WID'(w_sum) << (DATA_WID - CW));
        end

        assign stage_d[k] = w_next;

`ifdef SUB_OVERFLOW_FLAG_EN
        if (k == LAST) begin : g_ovf
            assign w_ovf_d = (w_a[CW-1] != w_b[CW-1]) && (w_sum[CW-1] != w_a[CW-1]);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!w_stall) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

`ifdef SUB_OVERFLOW_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (!w_stall) begin
            overflow_q <= w_ovf_d;
        end
    end

    assign overflow = overflow_q;
`endif

    assign out_valid  = stage_q[LAST].valid;
    assign diff       = stage_q[LAST].diff_lo[DATA_WID-1:0];
    assign borrow_out = stage_q[LAST].borrow;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipelined_cla_subtractor : scoreboard bench, random + directed beats vs arithmetic model
// Revision: 1.0   Define SUB_OVERFLOW_FLAG_EN to also check the overflow port
// ----------------------------------------------------------------------------
module tb_pipelined_cla_subtractor;

    localparam int W  = 32;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         overflow;
`endif

    pipelined_cla_subtractor #(
        .DATA_WID (W),
        .STAGES   (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    int   last_out_cyc = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain wide arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t            m;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned r;
        ua       = a;
        ub       = b;
        r        = ua - ub - longint'(bi);
        m.diff   = r[W-1:0];
        m.borrow = (ua < ub + longint'(bi));
        m.ovf    = (a[W-1] != b[W-1]) && (m.diff[W-1] != a[W-1]);
        m.acc    = 0;
        m.lat    = 1'b0;
        return m;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit lat, input bit rnd);
        exp_t x;
        @(posedge clk);
        #1;
        in1       = a;
        in2       = b;
        borrow_in = bi;
        in_valid  = 1'b1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                x.diff   = ed;
                x.borrow = eb;
                x.ovf    = eo;
                x.acc    = cyc;
                x.lat    = lat;
                q.push_back(x);
                last_acc = cyc;
                return;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'b1;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
    endtask

    task automatic send_rand(input bit lat, input bit rnd);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        exp_t         m;
        a  = $urandom;
        b  = $urandom;
        bi = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            1:       b = a;
            2:       a = W'($urandom_range(0, 7));
            3:       b = a + 1;
            default: ;
        endcase
        m = model(a, b, bi);
        send(a, b, bi, m.diff, m.borrow, m.ovf, lat, rnd);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a result transfers.
    logic [W-1:0] prev_diff;
    logic         prev_borrow;
    bit           prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_hold_diff", diff, prev_diff);
                chk("stall_hold_borrow", borrow_out, prev_borrow);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got diff %0h, expected no result", diff);
                end else begin
                    e = q.pop_front();
                    chk("diff", diff, e.diff);
                    chk("borrow_out", borrow_out, e.borrow);
`ifdef SUB_OVERFLOW_FLAG_EN
                    chk("overflow", overflow, e.ovf);
`endif
                    if (e.lat) chk("latency", cyc - e.acc, ST);
                    n_out++;
                    last_out_cyc = cyc;
                end
            end
            prev_stall  = out_valid && !out_ready;
            prev_diff   = diff;
            prev_borrow = borrow_out;
        end
    end

    initial begin
        int n0;
        int first_acc;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef SUB_OVERFLOW_FLAG_EN
        chk("rst_overflow", overflow, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed values, including wrap-around and the overflow corner cases.
        send(32'd100, 32'd58, 1'b0, 32'd42, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        drain();
        send(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        send(32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        send(32'd7, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        send(32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        drain();

        // Back-to-back burst: one result per cycle, in order.
        n0 = n_out;
        send_rand(1'b1, 1'b0);
        first_acc = last_acc;
        for (int i = 1; i < 16; i++) send_rand(1'b1, 1'b0);
        idle();
        drain();
        chk("burst_count", n_out - n0, 16);
        chk("burst_rate", last_out_cyc - first_acc, ST + 15);

        // Fill the pipe with the output blocked, hold, then release.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < ST; i++) send_rand(1'b0, 1'b0);
        idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("stall_count", n_out - n0, ST);

        // Random traffic with random downstream back-pressure.
        for (int i = 0; i < 60; i++) send_rand(1'b0, 1'b1);
        idle();
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight: they must vanish.
        for (int i = 0; i < 3; i++) send_rand(1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_rand(1'b1, 1'b0);
        idle();
        drain();
        repeat (ST + 2) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
